// File: rtl/store_buffer_bridge.sv
// Write-buffered CPU data port: stores retire into a FIFO and drain over a req/ack bus,
// while loads are ordered against buffered stores and stall the CPU until read data returns.
module store_buffer_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int LOAD_BYPASS = 1
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic [DATA_W/8-1:0]       cpu_wstrb,
  input  logic                      cpu_fence,
  output logic                      cpu_stall,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic [DATA_W/8-1:0]       bus_wstrb,
  input  logic                      bus_ack,
  input  logic [DATA_W-1:0]         bus_rdata,
  output logic [$clog2(DEPTH):0]    sb_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [STRB_W-1:0] fifo_strb_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0] bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              rd_done_q, rd_done_d;

  logic full, push, pop, load_pending, hit, load_ok;

  // Full comes from the registered count, so a pop never frees a slot in its own cycle.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign push         = cpu_req & cpu_we & ~full;
  assign pop          = (state_q == WR) & bus_ack;
  assign load_pending = cpu_req & ~cpu_we & ~rd_done_q;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin : hit_detect
    logic [PTR_W-1:0] idx;
    idx = '0;
    hit = (state_q == WR) && (bus_addr_q[ADDR_W-1:2] == cpu_addr[ADDR_W-1:2]);
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2]))
        hit = 1'b1;
    end
  end

  assign load_ok = (LOAD_BYPASS != 0) ? ~hit : (count_q == '0);

  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cpu_rdata_d = cpu_rdata_q;
    rd_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A waiting load outranks draining the buffer.
        if (load_pending && load_ok) begin
          state_d     = RD;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = cpu_addr;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end else if (count_q != '0) begin
          state_d     = WR;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = fifo_addr_q[rd_ptr_q];
          bus_wdata_d = fifo_data_q[rd_ptr_q];
          bus_wstrb_d = fifo_strb_q[rd_ptr_q];
        end
      end
      WR: if (bus_ack) begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
      RD: if (bus_ack) begin
        state_d     = IDLE;
        bus_req_d   = 1'b0;
        cpu_rdata_d = bus_rdata;
        rd_done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      cpu_rdata_q <= '0;
      rd_done_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cpu_rdata_q <= cpu_rdata_d;
      rd_done_q   <= rd_done_d;
    end
  end

  // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr;
      fifo_data_q[wr_ptr_q] <= cpu_wdata;
      fifo_strb_q[wr_ptr_q] <= cpu_wstrb;
    end
  end

  assign cpu_stall = (cpu_req & cpu_we & full) | load_pending |
                     (cpu_fence & ((count_q != '0) | (state_q != IDLE)));
  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign sb_count  = count_q;

endmodule
